full_subtractor: RTL and testbench
==================================

// Module: full_subtractor
// PURPOSE
//  Full subtractor: computes a - b - cin (borrow-in) and produces difference and borrow-out.
//  Combinational outputs give the arithmetic result with no clock dependency.
//  Registered copies give a one-cycle-latency, timing-clean version for pipelined datapaths.
//  WIDTH > 1 chains bit cells as a ripple-borrow subtractor: cin feeds the LSB, brf leaves the MSB.
// PARAMETERS
//  WIDTH  1  operand width in bits (>= 1); 1 = classic single-bit full subtractor
// PORTS
//  clk      in   1      single clock; all registers update on its rising edge
//  rst      in   1      asynchronous, active-high reset
//  a        in   WIDTH  minuend
//  b        in   WIDTH  subtrahend
//  cin      in   1      borrow-in to LSB (1 = subtract one extra)
//  in_valid in   1      qualifies a/b/cin for the registered path
//  diff     out  WIDTH  combinational difference
//  brf      out  1      combinational borrow-out from MSB
//  diff_q   out  WIDTH  registered difference
//  brf_q    out  1      registered borrow-out
//  out_valid out 1      registered in_valid; high when diff_q/brf_q are fresh
// BEHAVIOUR
//  - Per bit i (bw[0]=cin): d[i] = a[i]^b[i]^bw[i];
//    bw[i+1] = (~a[i]&b[i]) | (~(a[i]^b[i])&bw[i]); brf = bw[WIDTH].
//  - Equivalently, {brf,diff} = {1'b0,a} - {1'b0,b} - cin, modulo 2^(WIDTH+1).
//  - brf=1 iff unsigned a < b + cin. Otherwise diff is the exact unsigned result.
//    On underflow, diff wraps modulo 2^WIDTH.
//  - diff/brf are purely combinational. They settle after any input change, independent of clk/rst.
//  - Combinational outputs are not gated by in_valid or rst.
//  - Registered path, rising clk:
//    - if in_valid: diff_q<=diff, brf_q<=brf;
//    - else: diff_q/brf_q hold;
//    - always: out_valid<=in_valid.
//    - Latency is exactly 1 cycle. Back-to-back in_valid gives one result per cycle.
//  - rst asserted (any time, asynchronous): diff_q=0, brf_q=0, out_valid=0 immediately.
//    They stay 0 while rst is high.
//  - A transaction in flight when rst asserts is discarded.
//  - First capture after reset is on the first rising clk with rst low and in_valid high.
//  - No X-propagation masking: X inputs give X combinational outputs.
// TESTING
//  1 Exhaustive WIDTH=1, {a,b,cin}=0..7, 5ns each -> (diff,brf) =
//    00,11,11,01,10,00,00,11.
//  2 Registered path WIDTH=1: in_valid=1, a=0,b=1,cin=0 at edge N
//    -> edge N: diff_q=1, brf_q=1, out_valid=1. Next cycle in_valid=0 -> values hold, out_valid=0.
//  3 Async reset: assert rst mid-cycle with diff_q=1 -> diff_q=brf_q=out_valid=0 before the next clk edge.
//    Release, then in_valid a=1,b=0,cin=0 -> diff_q=1, brf_q=0.
//  4 WIDTH=8: a=8'h05, b=8'h03, cin=1 -> diff=8'h01, brf=0;
//    a=8'h00, b=8'h01, cin=0 -> diff=8'hFF, brf=1.
//  5 WIDTH=8 boundary: a=8'hFF, b=8'hFF, cin=1 -> diff=8'hFF, brf=1;
//    a=8'hFF, b=8'h00, cin=0 -> diff=8'hFF, brf=0.
//  6 WIDTH=8 random 1000 vectors, in_valid random
//    -> diff/brf match reference a-b-cin each cycle; diff_q/brf_q match one cycle later when in_valid was 1.

Source files
------------

// File: rtl/full_subtractor_if.sv
// Operand, result and valid signals of the subtractor.
// master drives operands, slave returns results.
interface full_subtractor_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] diff;
  logic             brf;
  logic [WIDTH-1:0] diff_q;
  logic             brf_q;
  logic             out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  diff, brf, diff_q, brf_q, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output diff, brf, diff_q, brf_q, out_valid
  );
endinterface

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor a - b - cin with a combinational
// result and a one-cycle registered copy qualified by in_valid.
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input logic              clk,
  input logic              rst,
  full_subtractor_if.slave bus
);

  logic [WIDTH:0]   bw;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] diff_r;
  logic             brf_r;
  logic             vld_r;

  // borrow ripples from cin at the LSB up to the MSB
  always_comb begin
    bw    = '0;
    d     = '0;
    bw[0] = bus.cin;
    for (int i = 0; i < WIDTH; i++) begin
      d[i]    = bus.a[i] ^ bus.b[i] ^ bw[i];
      bw[i+1] = (~bus.a[i] & bus.b[i])
              | (~(bus.a[i] ^ bus.b[i]) & bw[i]);
    end
  end

  assign bus.diff = d;
  assign bus.brf  = bw[WIDTH];

  // capture result on valid input, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_r <= '0;
      brf_r  <= 1'b0;
      vld_r  <= 1'b0;
    end else begin
      vld_r <= bus.in_valid;
      if (bus.in_valid) begin
        diff_r <= d;
        brf_r  <= bw[WIDTH];
      end
    end
  end

  assign bus.diff_q    = diff_r;
  assign bus.brf_q     = brf_r;
  assign bus.out_valid = vld_r;

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and random checks of full_subtractor at WIDTH 1 and 8
// against an arithmetic reference model.
module tb_full_subtractor;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  full_subtractor_if #(.WIDTH(1)) b1 ();
  full_subtractor_if #(.WIDTH(8)) b8 ();

  full_subtractor #(.WIDTH(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  full_subtractor #(.WIDTH(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {brf, diff} from plain integer arithmetic
  function automatic logic [8:0] ref_sub(input int w,
                                         input int a,
                                         input int b,
                                         input int c);
    int r;
    logic [8:0] o;
    r = a - b - c;
    o[8]   = (r < 0);
    o[7:0] = 8'(r & ((1 << w) - 1));
    return o;
  endfunction

  initial begin
    logic [1:0] tbl [8];
    logic [8:0] m;
    logic [7:0] hd;
    logic       hb;
    logic       iv;
    int ra, rb, rc;

    n_vec = 0;
    n_err = 0;
    tbl = '{2'b00, 2'b11, 2'b11, 2'b01,
            2'b10, 2'b00, 2'b00, 2'b11};

    rst = 1'b1;
    b1.a = '0; b1.b = '0; b1.cin = 1'b0; b1.in_valid = 1'b0;
    b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.in_valid = 1'b0;
    #1;
    chk("rst_diff_q1", 8'(b1.diff_q), 8'h0);
    chk("rst_brf_q1", 8'(b1.brf_q), 8'h0);
    chk("rst_ov1", 8'(b1.out_valid), 8'h0);
    chk("rst_diff_q8", b8.diff_q, 8'h0);
    chk("rst_ov8", 8'(b8.out_valid), 8'h0);

    // exhaustive single bit, rst held high
    for (int v = 0; v < 8; v++) begin
      {b1.a, b1.b, b1.cin} = 3'(v);
      #5;
      chk("exh_diff", 8'(b1.diff), 8'(tbl[v][1]));
      chk("exh_brf", 8'(b1.brf), 8'(tbl[v][0]));
    end
    chk("rst_hold_dq", 8'(b1.diff_q), 8'h0);

    // registered path
    @(negedge clk);
    rst = 1'b0;
    b1.in_valid = 1'b1;
    b1.a = 1'b0; b1.b = 1'b1; b1.cin = 1'b0;
    @(posedge clk); #1;
    chk("reg_diff_q", 8'(b1.diff_q), 8'h1);
    chk("reg_brf_q", 8'(b1.brf_q), 8'h1);
    chk("reg_ov", 8'(b1.out_valid), 8'h1);
    @(negedge clk);
    b1.in_valid = 1'b0;
    b1.a = 1'b1; b1.b = 1'b0;
    @(posedge clk); #1;
    chk("hold_diff_q", 8'(b1.diff_q), 8'h1);
    chk("hold_brf_q", 8'(b1.brf_q), 8'h1);
    chk("hold_ov", 8'(b1.out_valid), 8'h0);

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_diff_q", 8'(b1.diff_q), 8'h0);
    chk("arst_brf_q", 8'(b1.brf_q), 8'h0);
    chk("arst_ov", 8'(b1.out_valid), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    b1.in_valid = 1'b1;
    b1.a = 1'b1; b1.b = 1'b0; b1.cin = 1'b0;
    @(posedge clk); #1;
    chk("post_diff_q", 8'(b1.diff_q), 8'h1);
    chk("post_brf_q", 8'(b1.brf_q), 8'h0);
    chk("post_ov", 8'(b1.out_valid), 8'h1);
    @(negedge clk);
    b1.in_valid = 1'b0;

    // WIDTH 8 directed and boundary
    b8.a = 8'h05; b8.b = 8'h03; b8.cin = 1'b1; #1;
    chk("w8_d1", b8.diff, 8'h01);
    chk("w8_b1", 8'(b8.brf), 8'h0);
    b8.a = 8'h00; b8.b = 8'h01; b8.cin = 1'b0; #1;
    chk("w8_d2", b8.diff, 8'hFF);
    chk("w8_b2", 8'(b8.brf), 8'h1);
    b8.a = 8'hFF; b8.b = 8'hFF; b8.cin = 1'b1; #1;
    chk("w8_d3", b8.diff, 8'hFF);
    chk("w8_b3", 8'(b8.brf), 8'h1);
    b8.a = 8'hFF; b8.b = 8'h00; b8.cin = 1'b0; #1;
    chk("w8_d4", b8.diff, 8'hFF);
    chk("w8_b4", 8'(b8.brf), 8'h0);

    // random WIDTH 8 with registered scoreboard
    hd = 8'h00;
    hb = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      ra = int'($urandom_range(255));
      rb = int'($urandom_range(255));
      rc = int'($urandom_range(1));
      iv = 1'($urandom_range(1));
      b8.a = 8'(ra); b8.b = 8'(rb);
      b8.cin = 1'(rc); b8.in_valid = iv;
      #1;
      m = ref_sub(8, ra, rb, rc);
      chk("rnd_diff", b8.diff, m[7:0]);
      chk("rnd_brf", 8'(b8.brf), 8'(m[8]));
      if (iv) begin
        hd = m[7:0];
        hb = m[8];
      end
      @(posedge clk); #1;
      chk("rnd_diff_q", b8.diff_q, hd);
      chk("rnd_brf_q", 8'(b8.brf_q), 8'(hb));
      chk("rnd_ov", 8'(b8.out_valid), 8'(iv));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
